// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
//   pll_state_e : supervisor FSM states
//   CNT_W       : width of the shared state counter
//   retry_w     : width of the retry counter (never zero)
package pll_sup_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    QUALIFY,
    LOCKED,
    FAIL
  } pll_state_e;

  // Counter must reach (largest cycle parameter - 1).
  function automatic int unsigned CNT_W(input int unsigned reset_cycles,
                                        input int unsigned lock_timeout,
                                        input int unsigned stable_cycles);
    int unsigned m;
    m = reset_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // MAX_RETRIES = 0 still needs a 1-bit port.
  function automatic int unsigned retry_w(input int unsigned max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : synchronous active-high reset (both flops clear to 0)
//   d   : asynchronous input
//   q   : synchronized output, two edges of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Fabric-side sequencer for an iCE40 PLL: pulses RESETB, qualifies the asynchronous
// LOCK, retries on timeout, falls back to bypass after repeated failure and produces
// the downstream synchronous reset.
//   clk, rst          : fabric clock, synchronous active-high reset
//   lock_in           : PLL LOCK (asynchronous)
//   dly_value/valid   : DYNAMICDELAY update request
//   dly_ready         : update accepted this cycle if dly_valid (combinational)
//   pll_resetb        : to PLL RESETB
//   pll_bypass        : to PLL BYPASS
//   pll_dynamicdelay  : to PLL DYNAMICDELAY
//   sys_rst           : downstream reset, released only in LOCKED / FAIL
//   locked, failed    : status
//   retry_count       : retries consumed in the current lock sequence
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               lock_in,
  input  logic [7:0]                         dly_value,
  input  logic                               dly_valid,
  output logic                               dly_ready,
  output logic                               pll_resetb,
  output logic                               pll_bypass,
  output logic [7:0]                         pll_dynamicdelay,
  output logic                               sys_rst,
  output logic                               locked,
  output logic                               failed,
  output logic [retry_w(MAX_RETRIES)-1:0]    retry_count
);

  localparam int unsigned CntW   = CNT_W(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned RetryW = retry_w(MAX_RETRIES);

  localparam logic [CntW-1:0]   ResetLast   = CntW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0]   StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

  logic lock_s;

  pll_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [7:0]        dly_q, dly_d;
  logic              resetb_q, resetb_d;
  logic              bypass_q, bypass_d;
  logic              sys_rst_q, sys_rst_d;
  logic              locked_q, locked_d;
  logic              failed_q, failed_d;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (lock_in),
    .q   (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    dly_d     = dly_q;
    // Lock loss wins over a delay update: no handshake while lock_s is low.
    dly_ready = (state_q == LOCKED) && lock_s;

    unique case (state_q)
      HOLD: begin
        if (cnt_q == ResetLast) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = QUALIFY;
        end else if (cnt_q == TimeoutLast) begin
          if (retry_q == RetryMax) begin
            state_d = FAIL;
          end else begin
            retry_d = retry_q + RetryW'(1);
            state_d = HOLD;
          end
        end
      end
      QUALIFY: begin
        // Dropping back restarts the timeout without consuming a retry.
        if (!lock_s) state_d = WAIT_LOCK;
        else if (cnt_q == StableLast) state_d = LOCKED;
      end
      LOCKED: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (dly_valid) begin
          // New delay only takes effect after a PLL reset.
          dly_d   = dly_value;
          state_d = HOLD;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = HOLD;
      end
    endcase

    if (state_d == LOCKED) retry_d = '0;

    // Shared counter restarts on every state entry.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CntW'(1);

    // Registered Moore decodes of the next state.
    resetb_d  = (state_d == WAIT_LOCK) || (state_d == QUALIFY) || (state_d == LOCKED);
    bypass_d  = (state_d == FAIL);
    sys_rst_d = !((state_d == LOCKED) || (state_d == FAIL));
    locked_d  = (state_d == LOCKED);
    failed_d  = (state_d == FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      retry_q   <= '0;
      dly_q     <= 8'h00;
      resetb_q  <= 1'b0;
      bypass_q  <= 1'b0;
      sys_rst_q <= 1'b1;
      locked_q  <= 1'b0;
      failed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      dly_q     <= dly_d;
      resetb_q  <= resetb_d;
      bypass_q  <= bypass_d;
      sys_rst_q <= sys_rst_d;
      locked_q  <= locked_d;
      failed_q  <= failed_d;
    end
  end

  assign pll_resetb       = resetb_q;
  assign pll_bypass       = bypass_q;
  assign pll_dynamicdelay = dly_q;
  assign sys_rst          = sys_rst_q;
  assign locked           = locked_q;
  assign failed           = failed_q;
  assign retry_count      = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus randomized lock_in / delay /
// reset traffic, all checked against a phase-and-timestamp reference model.
module tb_pll_lock_supervisor;

  localparam int unsigned RC = 4;
  localparam int unsigned LT = 32;
  localparam int unsigned SC = 8;
  localparam int unsigned MR = 2;

  localparam int PhHold = 0;
  localparam int PhWait = 1;
  localparam int PhQual = 2;
  localparam int PhLock = 3;
  localparam int PhFail = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock_in = 1'b0;
  logic [7:0] dly_value = 8'h00;
  logic       dly_valid = 1'b0;
  logic       dly_ready, pll_resetb, pll_bypass, sys_rst, locked, failed;
  logic [7:0] pll_dynamicdelay;
  logic [1:0] retry_count;

  pll_lock_supervisor #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MR)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .lock_in          (lock_in),
    .dly_value        (dly_value),
    .dly_valid        (dly_valid),
    .dly_ready        (dly_ready),
    .pll_resetb       (pll_resetb),
    .pll_bypass       (pll_bypass),
    .pll_dynamicdelay (pll_dynamicdelay),
    .sys_rst          (sys_rst),
    .locked           (locked),
    .failed           (failed),
    .retry_count      (retry_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase plus the edge at which it was entered; lock_in is seen
  // by the decision logic two edges after it is sampled.
  int         m_phase = PhHold;
  longint     m_edge = 0;
  longint     m_entry = 0;
  int         m_retries = 0;
  logic [7:0] m_delay = 8'h00;
  bit         m_s1 = 1'b0;
  bit         m_s2 = 1'b0;
  bit         m_valid = 1'b0;

  task automatic model_step();
    int spent;
    int nxt;
    m_edge++;
    if (rst) begin
      m_valid   = 1'b1;
      m_phase   = PhHold;
      m_entry   = m_edge;
      m_retries = 0;
      m_delay   = 8'h00;
      m_s1      = 1'b0;
      m_s2      = 1'b0;
    end else if (m_valid) begin
      spent = int'(m_edge - m_entry);
      nxt   = m_phase;
      case (m_phase)
        PhHold: if (spent == int'(RC)) nxt = PhWait;
        PhWait: begin
          if (m_s2) nxt = PhQual;
          else if (spent == int'(LT)) begin
            if (m_retries == int'(MR)) nxt = PhFail;
            else begin
              m_retries++;
              nxt = PhHold;
            end
          end
        end
        PhQual: begin
          if (!m_s2) nxt = PhWait;
          else if (spent == int'(SC)) nxt = PhLock;
        end
        PhLock: begin
          if (!m_s2) nxt = PhWait;
          else if (dly_valid) begin
            m_delay = dly_value;
            nxt     = PhHold;
          end
        end
        default: ;
      endcase
      if (nxt != m_phase) m_entry = m_edge;
      if (nxt == PhLock) m_retries = 0;
      m_phase = nxt;
      m_s2    = m_s1;
      m_s1    = lock_in;
    end
  endtask

  function automatic logic [15:0] exp_outs();
    logic e_resetb;
    e_resetb = (m_phase == PhWait) || (m_phase == PhQual) || (m_phase == PhLock);
    return {e_resetb, m_phase == PhFail, !((m_phase == PhLock) || (m_phase == PhFail)),
            m_phase == PhLock, m_phase == PhFail, (m_phase == PhLock) && m_s2,
            2'(m_retries), m_delay};
  endfunction

  function automatic logic [15:0] act_outs();
    return {pll_resetb, pll_bypass, sys_rst, locked, failed, dly_ready, retry_count,
            pll_dynamicdelay};
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) check_eq("model", act_outs(), exp_outs());
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  // Leaves the caller at the first negedge after the reset edge, rst released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dly_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq(tag, act_outs(), 16'h2000);
  endtask

  int  lo, n, cyc, run, npulse;
  bit  ok, seen;

  initial begin
    // 1. Clean lock
    lock_in = 1'b0;
    do_reset();
    check_reset("t1_reset_vals");
    lo = 0;
    while (pll_resetb == 1'b0 && lo < 100) begin lo++; @(negedge clk); end
    check_eq("t1_hold_len", lo, 4);
    repeat (10) @(negedge clk);
    lock_in = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("t1_locked_early", locked, 1'b0);
    @(negedge clk);
    check_eq("t1_locked", locked, 1'b1);
    check_eq("t1_sys_rst", sys_rst, 1'b0);

    // 4. Lock loss and relock without reset pulse
    lock_in = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t4_sys_rst_low", sys_rst, 1'b0);
    @(negedge clk);
    check_eq("t4_sys_rst", sys_rst, 1'b1);
    check_eq("t4_resetb", pll_resetb, 1'b1);
    lock_in = 1'b1;
    ok = 1'b1;
    repeat (10) begin @(negedge clk); if (!pll_resetb) ok = 1'b0; end
    check_eq("t4_relock_early", locked, 1'b0);
    @(negedge clk);
    check_eq("t4_relock", locked, 1'b1);
    check_eq("t4_no_reset_pulse", ok, 1'b1);

    // 5. Delay update
    check_eq("t5_ready", dly_ready, 1'b1);
    dly_value = 8'hA5;
    dly_valid = 1'b1;
    @(negedge clk);
    dly_valid = 1'b0;
    check_eq("t5_delay", pll_dynamicdelay, 8'hA5);
    ok = 1'b1;
    lo = 0;
    while (!pll_resetb && lo < 100) begin
      if (!sys_rst) ok = 1'b0;
      lo++;
      @(negedge clk);
    end
    check_eq("t5_pulse_len", lo, 4);
    n = 0;
    while (!locked && n < 100) begin
      if (!sys_rst) ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check_eq("t5_relock", locked, 1'b1);
    check_eq("t5_sys_rst_held", ok, 1'b1);
    // Transfer attempt while synchronized lock is already gone
    lock_in = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t5_ready_lost", dly_ready, 1'b0);
    dly_value = 8'h5A;
    dly_valid = 1'b1;
    @(negedge clk);
    dly_valid = 1'b0;
    check_eq("t5_no_transfer", pll_dynamicdelay, 8'hA5);
    check_eq("t5_no_pulse", pll_resetb, 1'b1);
    check_eq("t5_sys_rst_lost", sys_rst, 1'b1);

    // 6a. Reset while qualifying
    lock_in = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("t6_in_qualify", {pll_resetb, locked}, 2'b10);
    do_reset();
    check_reset("t6_reset_qualify");

    // 2. Glitchy lock
    lock_in = 1'b0;
    lo = 0;
    while (!pll_resetb && lo < 100) begin lo++; @(negedge clk); end
    seen = 1'b0;
    lock_in = 1'b1;
    repeat (5) begin @(negedge clk); if (locked) seen = 1'b1; end
    lock_in = 1'b0;
    @(negedge clk);
    if (locked) seen = 1'b1;
    lock_in = 1'b1;
    repeat (10) begin @(negedge clk); if (locked) seen = 1'b1; end
    check_eq("t2_no_early_lock", seen, 1'b0);
    @(negedge clk);
    check_eq("t2_locked", locked, 1'b1);
    check_eq("t2_retry", retry_count, 2'd0);

    // 3. Timeout, retries, fail
    lock_in = 1'b0;
    do_reset();
    cyc = 0;
    run = 0;
    npulse = 0;
    while (!failed && cyc < 400) begin
      if (!pll_resetb) begin
        run++;
      end else if (run != 0) begin
        check_eq("t3_pulse_len", run, 4);
        check_eq("t3_retry", retry_count, npulse);
        npulse++;
        run = 0;
      end
      cyc++;
      @(negedge clk);
    end
    check_eq("t3_time_to_fail", cyc, (MR + 1) * (RC + LT));
    check_eq("t3_pulses", npulse, MR + 1);
    check_eq("t3_fail_outs", {failed, pll_bypass, sys_rst, pll_resetb, locked}, 5'b11000);

    // 6b. Reset from FAIL
    do_reset();
    check_reset("t6_reset_fail");

    // Randomized traffic, checked only by the model
    for (int seg = 0; seg < 200; seg++) begin
      int len;
      lock_in = ($urandom_range(0, 9) < 7);
      len = $urandom_range(1, 60);
      repeat (len) begin
        dly_valid = ($urandom_range(0, 15) == 0);
        dly_value = 8'($urandom);
        rst       = ($urandom_range(0, 299) == 0);
        @(negedge clk);
      end
    end
    rst = 1'b0;
    dly_valid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Fabric-side controller for an iCE40 `SB_PLL40_PAD`/`SB_PLL40_CORE` instance. It drives the PLL `RESETB`, `BYPASS` and `DYNAMICDELAY` inputs and consumes its asynchronous `LOCK` output. It sequences PLL reset, qualifies lock, retries on timeout and falls back to bypass after repeated failure. It produces the synchronous `sys_rst` that releases the downstream design once the PLL clock is trustworthy.

## Interface
Parameters:
- `RESET_CYCLES`, 16: cycles `pll_resetb` is held low per reset attempt (≥2).
- `LOCK_TIMEOUT`, 4096: cycles allowed in WAIT_LOCK before a retry (≥2).
- `STABLE_CYCLES`, 256: consecutive synchronized-high `LOCK` cycles required to declare lock (≥1).
- `MAX_RETRIES`, 3: reset retries allowed before FAIL (≥0).

Ports:
- `clk`  in  1  free-running fabric clock, independent of PLL output.
- `rst`  in  1  synchronous, active-high reset.
- `lock_in`  in  1  PLL `LOCK`; asynchronous.
- `dly_value`  in  8  requested `DYNAMICDELAY` value.
- `dly_valid`  in  1  delay update request.
- `dly_ready`  out  1  combinational: `state==LOCKED && lock_s`.
- `pll_resetb`  out  1  to PLL `RESETB`.
- `pll_bypass`  out  1  to PLL `BYPASS`.
- `pll_dynamicdelay`  out  8  to PLL `DYNAMICDELAY`.
- `sys_rst`  out  1  active-high reset for the downstream design.
- `locked`  out  1  qualified lock.
- `failed`  out  1  retries exhausted; PLL bypassed.
- `retry_count`  out  $clog2(MAX_RETRIES+1)  retries consumed in the current sequence.

## Operation
- `lock_in` passes through a 2-flop synchronizer to produce `lock_s`. Nothing else samples `lock_in`.
- One counter `cnt` is shared by all states and cleared on every state entry.
- **HOLD:** `pll_resetb=0`. When `cnt==RESET_CYCLES-1`, go to WAIT_LOCK.
- **WAIT_LOCK:** `pll_resetb=1`.
  - `lock_s=1` → QUALIFY.
  - Else, when `cnt==LOCK_TIMEOUT-1`: if `retry_count==MAX_RETRIES` → FAIL; otherwise increment `retry_count` and go to HOLD.
- **QUALIFY:**
  - `lock_s=0` → WAIT_LOCK. The timeout restarts; this does not count as a retry.
  - When `cnt==STABLE_CYCLES-1` with `lock_s=1` → LOCKED.
- **LOCKED:** `sys_rst=0`, `locked=1`, and `retry_count` is cleared.
  - `lock_s=0` → WAIT_LOCK without a PLL reset; `sys_rst` reasserts.
  - Otherwise, `dly_valid && dly_ready` loads `dly_value` into `pll_dynamicdelay` and goes to HOLD, because the PLL is re-reset to apply the new delay.
  - Lock loss has priority: in a cycle with `lock_s=0`, `dly_ready=0` and no transfer occurs.
- **FAIL:** terminal until `rst`. Outputs: `pll_bypass=1`, `pll_resetb=0`, `failed=1`, `locked=0`, `sys_rst=0`. The design runs on the bypassed reference.
- `sys_rst=1` in every state except LOCKED and FAIL.
- `pll_dynamicdelay` changes only on an accepted transfer.

## Timing
- Reset values: state=HOLD, `cnt=0`, `pll_resetb=0`, `pll_bypass=0`, `pll_dynamicdelay=8'h00`, `sys_rst=1`, `locked=0`, `failed=0`, `retry_count=0`, `dly_ready=0`, synchronizer flops=0.
- All outputs except `dly_ready` are registered Moore decodes of the next state; each changes on the same edge the state changes.
- `pll_resetb` low-time is exactly `RESET_CYCLES` per attempt.
- Latency from `lock_in` rising (steady) in WAIT_LOCK to `locked=1` is 2 (sync) + 1 (enter QUALIFY) + `STABLE_CYCLES` edges.
- Latency from `lock_in` falling in LOCKED to `sys_rst=1` is 3 edges.
- Worst case to FAIL is (MAX_RETRIES+1)×(RESET_CYCLES+LOCK_TIMEOUT) cycles after `rst` release.
- `rst` asserted in any state, including FAIL or mid-QUALIFY, restores reset values on the next edge. `pll_dynamicdelay` also returns to 0.

## Structure
- `pll_sup_pkg` holds:
  - the state typedef (`HOLD`, `WAIT_LOCK`, `QUALIFY`, `LOCKED`, `FAIL`);
  - a `CNT_W` function returning `$clog2` of the largest of the three cycle parameters.
- Sub-module `sync_2ff` (1-bit, reset value 0) is reused elsewhere for asynchronous inputs.

## Test plan
Bench parameters: `RESET_CYCLES=4`, `LOCK_TIMEOUT=32`, `STABLE_CYCLES=8`, `MAX_RETRIES=2`.

1. Clean lock: raise `lock_in` 10 cycles after `pll_resetb` rises → `pll_resetb` was low exactly 4 cycles; `locked`=1 and `sys_rst`=0 exactly 11 edges after `lock_in` rises.
2. Glitchy lock: hold `lock_in` high 5 cycles, low 1, then high → no `locked` during the glitch; `locked` asserts 8 qualified cycles after the final rise; `retry_count`=0.
3. Timeout and retry: `lock_in`=0 forever → `retry_count` steps 0→1→2 with a 4-cycle `pll_resetb` pulse each time; after the third timeout, `failed`=1, `pll_bypass`=1, `sys_rst`=0.
4. Lock loss: in LOCKED, drop `lock_in` → `sys_rst`=1 3 edges later and `pll_resetb` stays 1; restore `lock_in` → relock without a reset pulse.
5. Delay update: in LOCKED, `dly_value=8'hA5` with `dly_valid` for 1 cycle → `pll_dynamicdelay`=8'hA5, a 4-cycle `pll_resetb` low pulse, `sys_rst`=1 until relock. Repeat with `lock_in` falling the same cycle → no transfer.
6. Reset mid-operation: assert `rst` in QUALIFY and in FAIL → all outputs at reset values next edge; `pll_dynamicdelay`=0.
